// File: rtl/vd_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vd_frame_ctrl_if
// Description : Code-symbol stream from the convolutional encoder into the
//               Viterbi frame controller (valid/ready handshake).
// Revision    : 1.0 - initial release
// ============================================================================
interface vd_frame_ctrl_if;
  logic [1:0] sym_in;     // rate-1/2 code symbol
  logic       sym_valid;  // sym_in carries a symbol
  logic       sym_ready;  // controller takes the symbol this cycle

  // Encoder side
  modport master (
    output sym_in,
    output sym_valid,
    input  sym_ready
  );

  // Frame controller side
  modport slave (
    input  sym_in,
    input  sym_valid,
    output sym_ready
  );
endinterface
`default_nettype wire

// File: rtl/vd_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vd_frame_ctrl
// Description : Frame sequencer in front of a Viterbi decoder. Feeds FRAME_LEN
//               code symbols, appends TAIL_LEN zero symbols to terminate the
//               trellis, drains the decoder for DEC_LATENCY active cycles and
//               forwards only the decoded information bits.
// Revision    : 1.0 - initial release
// ============================================================================
module vd_frame_ctrl #(
  parameter int FRAME_LEN   = 64,  // information symbols per frame
  parameter int TAIL_LEN    = 8,   // zero tail symbols (K-1)
  parameter int DEC_LATENCY = 32,  // decoder delay in active cycles
  parameter int CNT_W       = 8    // symbol / phase counter width
) (
  input  wire logic             CLOCK,
  input  wire logic             Reset,
  input  wire logic             start,
  input  wire logic             abort,
  vd_frame_ctrl_if.slave        sym,
  output logic                  dec_active,
  output logic [1:0]            dec_code,
  input  wire logic             dec_bit_in,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      sym_count
);

  // Terminal counts for the symbol and phase counters.
  localparam logic [CNT_W-1:0] c_frame_len  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] c_frame_last = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] c_tail_last  = CNT_W'(TAIL_LEN - 1);
  localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(DEC_LATENCY - 1);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_phase;     // cycles spent in FLUSH / DRAIN
  logic                   r_tag_cur;   // tag of the symbol now on dec_code
  logic [DEC_LATENCY-1:0] r_tag;       // tags of symbols inside the decoder
  logic [DEC_LATENCY-1:0] w_tag_next;
  logic                   w_abort;
  logic                   w_accept;

  // Abort only has meaning while a frame is in progress.
  assign w_abort  = abort && (r_state != S_IDLE);
  assign sym.sym_ready = (r_state == S_FEED);
  assign w_accept = sym.sym_valid && (r_state == S_FEED) && !w_abort;
  assign busy     = (r_state != S_IDLE);

  // Tag register shifted by one position with the current symbol's tag.
  generate
    if (DEC_LATENCY > 1) begin : g_tag_deep
      assign w_tag_next = {r_tag[DEC_LATENCY-2:0], r_tag_cur};
    end else begin : g_tag_single
      assign w_tag_next = r_tag_cur;
    end
  endgenerate

  // Frame sequencing: state, decoder drive, symbol and phase counting.
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_tag_cur  <= 1'b0;
      dec_active <= 1'b0;
      dec_code   <= 2'b00;
      frame_done <= 1'b0;
      sym_count  <= '0;
    end else if (w_abort) begin
      // Drop the frame silently; dec_code and sym_count keep their values.
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_tag_cur  <= 1'b0;
      dec_active <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          dec_active <= 1'b0;
          r_tag_cur  <= 1'b0;
          if (start) begin
            r_state   <= S_FEED;
            sym_count <= '0;
            r_phase   <= '0;
          end
        end

        S_FEED: begin
          if (w_accept) begin
            dec_active <= 1'b1;
            dec_code   <= sym.sym_in;
            r_tag_cur  <= 1'b1;
            if (sym_count != c_frame_len) begin
              sym_count <= sym_count + c_cnt_one;
            end
            if (sym_count == c_frame_last) begin
              r_state <= S_FLUSH;
            end
          end else begin
            // Stall: decoder frozen, code held for the next accepted symbol.
            dec_active <= 1'b0;
            r_tag_cur  <= 1'b0;
          end
        end

        S_FLUSH: begin
          dec_active <= 1'b1;
          dec_code   <= 2'b00;
          r_tag_cur  <= 1'b0;
          if (r_phase == c_tail_last) begin
            r_phase <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_phase <= r_phase + c_cnt_one;
          end
        end

        S_DRAIN: begin
          dec_active <= 1'b1;
          dec_code   <= 2'b00;
          r_tag_cur  <= 1'b0;
          if (r_phase == c_drain_last) begin
            r_phase <= '0;
            r_state <= S_DONE;
          end else begin
            r_phase <= r_phase + c_cnt_one;
          end
        end

        S_DONE: begin
          // The cycle in this state is still the last active cycle.
          dec_active <= 1'b0;
          r_tag_cur  <= 1'b0;
          frame_done <= 1'b1;
          r_state    <= S_IDLE;
        end

        default: begin
          dec_active <= 1'b0;
          r_tag_cur  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Output tagging: advance only at the end of an active cycle, so decoder
  // stalls never misalign the tag stream with DecodeOut.
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      r_tag     <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else if (w_abort) begin
      r_tag     <= '0;
      bit_valid <= 1'b0;
    end else if (dec_active) begin
      bit_valid <= r_tag[DEC_LATENCY-1];
      bit_out   <= dec_bit_in;
      r_tag     <= w_tag_next;
    end else begin
      bit_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vd_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vd_frame_ctrl
// Description : Randomised self-checking bench for vd_frame_ctrl. Two DUTs
//               (FRAME_LEN 4 and 1) share the symbol stream; expected traces
//               are derived per frame from the accepted-symbol schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vd_frame_ctrl;
  localparam int FA   = 4;
  localparam int FB   = 1;
  localparam int TL   = 2;
  localparam int DL   = 3;
  localparam int CW   = 8;
  localparam int NLOG = 4096;
  localparam int WIN  = 512;

  logic clk = 1'b0;
  logic rst, start_a, start_b, abort_a, dec_bit;
  logic act_a, bo_a, bv_a, busy_a, done_a;
  logic act_b, bo_b, bv_b, busy_b, done_b;
  logic [1:0] code_a, code_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic abort_b;

  int cyc = 0;
  int abort_at = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic       v_log [NLOG];
  logic [1:0] s_log [NLOG];
  logic       b_log [NLOG];
  logic       m_act [2][NLOG];
  logic [1:0] m_code[2][NLOG];
  logic       m_bv  [2][NLOG];
  logic       m_bo  [2][NLOG];
  logic       m_busy[2][NLOG];
  logic       m_done[2][NLOG];
  logic       m_rdy [2][NLOG];

  vd_frame_ctrl_if ifa ();
  vd_frame_ctrl_if ifb ();

  vd_frame_ctrl #(.FRAME_LEN(FA), .TAIL_LEN(TL), .DEC_LATENCY(DL), .CNT_W(CW)) u_dut_a (
    .CLOCK(clk), .Reset(rst), .start(start_a), .abort(abort_a), .sym(ifa),
    .dec_active(act_a), .dec_code(code_a), .dec_bit_in(dec_bit),
    .bit_out(bo_a), .bit_valid(bv_a), .busy(busy_a), .frame_done(done_a),
    .sym_count(cnt_a)
  );

  vd_frame_ctrl #(.FRAME_LEN(FB), .TAIL_LEN(TL), .DEC_LATENCY(DL), .CNT_W(CW)) u_dut_b (
    .CLOCK(clk), .Reset(rst), .start(start_b), .abort(abort_b), .sym(ifb),
    .dec_active(act_b), .dec_code(code_b), .dec_bit_in(dec_bit),
    .bit_out(bo_b), .bit_valid(bv_b), .busy(busy_b), .frame_done(done_b),
    .sym_count(cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record stimulus and both DUTs' outputs mid-cycle.
  always @(negedge clk) begin
    if (cyc < NLOG) begin
      v_log[cyc]     <= ifa.sym_valid;
      s_log[cyc]     <= ifa.sym_in;
      b_log[cyc]     <= dec_bit;
      m_act[0][cyc]  <= act_a;   m_act[1][cyc]  <= act_b;
      m_code[0][cyc] <= code_a;  m_code[1][cyc] <= code_b;
      m_bv[0][cyc]   <= bv_a;    m_bv[1][cyc]   <= bv_b;
      m_bo[0][cyc]   <= bo_a;    m_bo[1][cyc]   <= bo_b;
      m_busy[0][cyc] <= busy_a;  m_busy[1][cyc] <= busy_b;
      m_done[0][cyc] <= done_a;  m_done[1][cyc] <= done_b;
      m_rdy[0][cyc]  <= ifa.sym_ready;
      m_rdy[1][cyc]  <= ifb.sym_ready;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic drive_sym(input logic v, input logic [1:0] d);
    ifa.sym_valid = v; ifa.sym_in = d;
    ifb.sym_valid = v; ifb.sym_in = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    abort_a = (abort_at != 0) && (cyc == abort_at);
    dec_bit = 1'($urandom);
  endtask

  // All outputs of one DUT packed, for reset checks against zero.
  function automatic logic [31:0] outs(input int d);
    if (d == 0) return {16'd0, cnt_a, code_a, act_a, bo_a, bv_a, busy_a, done_a, ifa.sym_ready};
    else        return {16'd0, cnt_b, code_b, act_b, bo_b, bv_b, busy_b, done_b, ifb.sym_ready};
  endfunction

  // Build the expected trace of one DUT over cycles s..e from the schedule of
  // accepted symbols, then compare against what was recorded.
  task automatic check_frame(input int d, input int fl, input int s, input int e,
                             input int x, input bit started);
    int acc[$];
    int act[$];
    int busy_end, rdy_end, k;
    bit ea[WIN], eb[WIN], ebo[WIN], ebusy[WIN], erdy[WIN], edone[WIN];
    logic [1:0] ec[WIN];
    string nm;
    nm = (d == 0) ? "A" : "B";
    for (int i = 0; i < WIN; i++) begin
      ea[i] = 0; eb[i] = 0; ebo[i] = 0; ebusy[i] = 0; erdy[i] = 0; edone[i] = 0; ec[i] = 2'b00;
    end
    if (started) begin
      for (int c = s + 1; c <= e && acc.size() < fl; c++)
        if (v_log[c] && (x == 0 || c < x)) acc.push_back(c);
      foreach (acc[i]) act.push_back(acc[i] + 1);
      if (acc.size() == fl)
        for (int t = 1; t <= TL + DL; t++) act.push_back(acc[fl-1] + 1 + t);
      busy_end = (x != 0) ? x : act[act.size()-1];
      rdy_end  = (acc.size() == fl) ? acc[fl-1] : x;
      for (int c = s + 1; c <= busy_end; c++) ebusy[c-s] = 1;
      for (int c = s + 1; c <= rdy_end; c++) erdy[c-s] = 1;
      foreach (act[i]) begin
        if (x == 0 || act[i] <= x) begin
          ea[act[i]-s] = 1;
          ec[act[i]-s] = (i < fl) ? s_log[acc[i]] : 2'b00;
        end
      end
      for (int j = 0; j < fl; j++) begin
        k = j + DL;
        if (k < act.size() && (x == 0 || act[k] < x)) begin
          eb[act[k]+1-s]  = 1;
          ebo[act[k]+1-s] = b_log[act[k]];
        end
      end
      if (x == 0) edone[act[act.size()-1]+1-s] = 1;
      check_val($sformatf("%s sym_count end@%0d", nm, e),
                (d == 0) ? 32'(cnt_a) : 32'(cnt_b), acc.size());
    end
    for (int c = s; c <= e; c++) begin
      check_val($sformatf("%s dec_active@%0d", nm, c), m_act[d][c], ea[c-s]);
      check_val($sformatf("%s busy@%0d", nm, c), m_busy[d][c], ebusy[c-s]);
      check_val($sformatf("%s sym_ready@%0d", nm, c), m_rdy[d][c], erdy[c-s]);
      check_val($sformatf("%s frame_done@%0d", nm, c), m_done[d][c], edone[c-s]);
      check_val($sformatf("%s bit_valid@%0d", nm, c), m_bv[d][c], eb[c-s]);
      if (ea[c-s]) check_val($sformatf("%s dec_code@%0d", nm, c), m_code[d][c], ec[c-s]);
      if (eb[c-s]) check_val($sformatf("%s bit_out@%0d", nm, c), m_bo[d][c], ebo[c-s]);
    end
  endtask

  // stall_mode: 0 none, 1 random, 2 two cycles after symbol 2.
  // abort_mode: 0 none, 1 first FLUSH cycle, 2 random point in the frame.
  task automatic run_frame(input int stall_mode, input bit fixed_syms, input bit do_b,
                           input bit extra_start, input int abort_mode);
    int s, e, nv, st;
    abort_at = 0;
    s = cyc;
    start_a = 1'b1;
    start_b = do_b;
    drive_sym(1'($urandom), 2'($urandom));
    if (abort_mode == 2) abort_at = s + $urandom_range(1, FA + TL + DL);
    next_cycle();
    start_a = 1'b0;
    start_b = 1'b0;
    nv = 0;
    st = 0;
    while (nv < FA) begin
      if ((stall_mode == 1 && st < 12 && $urandom_range(0, 2) == 0) ||
          (stall_mode == 2 && nv == 2 && st < 2)) begin
        drive_sym(1'b0, 2'($urandom));
        st++;
      end else begin
        drive_sym(1'b1, fixed_syms ? 2'(nv + 1) : 2'($urandom));
        nv++;
      end
      next_cycle();
    end
    drive_sym(1'($urandom), 2'($urandom));
    if (abort_mode == 1) begin
      abort_at = cyc;
      abort_a  = 1'b1;
    end
    if (extra_start) start_a = 1'b1;
    for (int i = 0; i < TL + DL + 4; i++) begin
      next_cycle();
      start_a = 1'b0;
      drive_sym(1'($urandom), 2'($urandom));
    end
    e = cyc - 1;
    check_frame(0, FA, s, e, abort_at, 1'b1);
    check_frame(1, FB, s, e, 0, do_b);
    abort_at = 0;
    abort_a  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    dec_bit = 1'b0;
    drive_sym(1'b0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check_val("A outputs in reset", outs(0), 32'd0);
    check_val("B outputs in reset", outs(1), 32'd0);
    rst = 1'b0;
    next_cycle();
    check_val("A outputs after reset", outs(0), 32'd0);

    // Reset asserted mid-FEED after two accepted symbols.
    start_a = 1'b1; start_b = 1'b1;
    next_cycle();
    start_a = 1'b0; start_b = 1'b0;
    drive_sym(1'b1, 2'b01);
    next_cycle();
    drive_sym(1'b1, 2'b10);
    next_cycle();
    drive_sym(1'b0, 2'b00);
    check_val("midfeed A sym_count", cnt_a, 2);
    check_val("midfeed A dec_active", act_a, 1);
    check_val("midfeed A dec_code", code_a, 2'b10);
    check_val("midfeed A busy", busy_a, 1);
    rst = 1'b1;
    #1;
    check_val("midfeed A outputs after async reset", outs(0), 32'd0);
    check_val("midfeed B outputs after async reset", outs(1), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_frame(0, 1'b1, 1'b1, 1'b0, 0);   // plain frame, symbols 01,10,11,00
    run_frame(2, 1'b1, 1'b1, 1'b0, 0);   // two-cycle stall after symbol 2
    run_frame(0, 1'b0, 1'b1, 1'b1, 0);   // start pulsed in FLUSH
    run_frame(0, 1'b0, 1'b0, 1'b0, 1);   // abort in first FLUSH cycle
    run_frame(1, 1'b0, 1'b1, 1'b0, 0);   // normal frame after the abort
    for (int f = 0; f < 30; f++) begin
      int am;
      am = ($urandom_range(0, 3) == 0) ? 2 : 0;
      run_frame(1, 1'b0, 1'($urandom), (am == 0) ? 1'($urandom) : 1'b0, am);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout after %0d cycles", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
